// File: rtl/csa_serial_adder_ctrl_pkg.sv
// Shared definitions for the nibble-serial add/subtract sequencer:
// state encoding, nibble width and a counter-width helper.
package csa_ctrl_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Number of bits needed to count n distinct values (ceil(log2(n))).
    function automatic int clog2(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/csa_serial_adder_ctrl_csa4.sv
// 4-bit carry-select adder: the low pair of bits ripples, and the high pair
// is precomputed for both carry values, then selected by the low-pair carry.
module carry_select_adder_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [2:0] lo;
    logic [2:0] hi0;
    logic [2:0] hi1;
    logic [2:0] hi;

    // Compute both high-half candidates and pick one with the low-half carry.
    always_comb begin
        lo   = {1'b0, a[1:0]} + {1'b0, b[1:0]} + {2'b00, cin};
        hi0  = {1'b0, a[3:2]} + {1'b0, b[3:2]};
        hi1  = {1'b0, a[3:2]} + {1'b0, b[3:2]} + 3'd1;
        hi   = lo[2] ? hi1 : hi0;
        sum  = {hi[1:0], lo[1:0]};
        cout = hi[2];
    end

endmodule

// File: rtl/csa_serial_adder_ctrl.sv
// Nibble-serial WIDTH-bit add/subtract. Operands are captured on the input
// handshake, pushed through one shared 4-bit adder LSB nibble first, and the
// result is held on the output handshake until consumed.
module csa_serial_adder_ctrl
    import csa_ctrl_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             op_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int CNT_W   = (NIBBLES > 1) ? clog2(NIBBLES) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NIBBLES - 1);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic [WIDTH-1:0] sum_sh_next;
    logic [WIDTH-1:0] b_eff;
    logic             carry;
    logic             a_msb;
    logic             b_msb;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       nib_sum;
    logic             nib_cout;
    logic             last_nib;

    // Subtraction is A + ~B + ~borrow, so B and the carry-in are inverted at capture.
    assign b_eff    = op_sub ? ~b : b;
    assign last_nib = (cnt == LAST_CNT);

    carry_select_adder_4bit u_nib_adder (
        .a    (a_sh[3:0]),
        .b    (b_sh[3:0]),
        .cin  (carry),
        .sum  (nib_sum),
        .cout (nib_cout)
    );

    // The new sum nibble enters at the top so the LSB nibble ends up at the bottom.
    generate
        if (WIDTH == NIBBLE_W) begin : g_single
            assign sum_sh_next = nib_sum;
        end else begin : g_multi
            assign sum_sh_next = {nib_sum, sum_sh[WIDTH-1:NIBBLE_W]};
        end
    endgenerate

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: accept, run NIBBLES cycles, wait for the consumer.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (in_valid)  state_next = ST_RUN;
            ST_RUN:  if (last_nib)  state_next = ST_DONE;
            ST_DONE: if (out_ready) state_next = ST_IDLE;
            default:                state_next = ST_IDLE;
        endcase
    end

    // Handshake outputs decoded purely from the state register.
    always_comb begin
        in_ready  = (state == ST_IDLE);
        out_valid = (state == ST_DONE);
    end

    // Operand capture, nibble shifting and result publication.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh     <= '0;
            b_sh     <= '0;
            sum_sh   <= '0;
            carry    <= 1'b0;
            a_msb    <= 1'b0;
            b_msb    <= 1'b0;
            cnt      <= '0;
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_sh  <= a;
                        b_sh  <= b_eff;
                        carry <= op_sub ? ~cin : cin;
                        a_msb <= a[WIDTH-1];
                        b_msb <= b_eff[WIDTH-1];
                        cnt   <= '0;
                    end
                end
                ST_RUN: begin
                    a_sh   <= a_sh >> NIBBLE_W;
                    b_sh   <= b_sh >> NIBBLE_W;
                    sum_sh <= sum_sh_next;
                    carry  <= nib_cout;
                    cnt    <= cnt + 1'b1;
                    if (last_nib) begin
                        sum      <= sum_sh_next;
                        cout     <= nib_cout;
                        overflow <= (a_msb == b_msb) && (sum_sh_next[WIDTH-1] != a_msb);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_csa_serial_adder_ctrl.sv
// Directed, table-driven bench for the nibble-serial adder sequencer.
module tb_csa_serial_adder_ctrl;

    localparam int WIDTH   = 16;
    localparam int NIBBLES = WIDTH / 4;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        op_sub;
        logic [15:0] exp_sum;
        logic        exp_cout;
        logic        exp_ovf;
    } vec_t;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             op_sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;

    int checks = 0;
    int fails  = 0;

    vec_t vecs[10];

    csa_serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .op_sub    (op_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .overflow  (overflow)
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something wedges outside the bounded waits.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic waitReady();
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("in_ready_wait", 32'(in_ready), 32'd1);
    endtask

    // Issue one operation, scramble the inputs afterwards, and verify latency.
    task automatic applyStimulus(input logic [15:0] va, input logic [15:0] vb,
                                 input logic vcin, input logic vsub);
        waitReady();
        a        = va;
        b        = vb;
        cin      = vcin;
        op_sub   = vsub;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = 16'($urandom);
        b        = 16'($urandom);
        cin      = ~vcin;
        op_sub   = ~vsub;
        for (int k = 1; k <= NIBBLES; k++) begin
            @(posedge clk);
            #1;
            checkOutput("latency_out_valid", 32'(out_valid), 32'(k == NIBBLES));
            checkOutput("in_ready_busy", 32'(in_ready), 32'd0);
        end
    endtask

    task automatic takeResult();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checkOutput("out_valid_after_take", 32'(out_valid), 32'd0);
        checkOutput("in_ready_after_take", 32'(in_ready), 32'd1);
    endtask

    initial begin
        //          a        b        cin   sub   sum      cout  ovf
        vecs[0] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[3] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[4] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFD, 1'b0, 1'b0};
        vecs[5] = '{16'h00FF, 16'h0000, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b0};
        vecs[6] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vecs[7] = '{16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[8] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[9] = '{16'hA5A5, 16'h5A5A, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};

        rst_n     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        op_sub    = 1'b0;

        // Reset asserted between edges must act immediately.
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_sum", 32'(sum), 32'h0);
        checkOutput("reset_cout", 32'(cout), 32'd0);
        checkOutput("reset_overflow", 32'(overflow), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].op_sub);
            checkOutput($sformatf("vec%0d_sum", i), 32'(sum), 32'(vecs[i].exp_sum));
            checkOutput($sformatf("vec%0d_cout", i), 32'(cout), 32'(vecs[i].exp_cout));
            checkOutput($sformatf("vec%0d_overflow", i), 32'(overflow), 32'(vecs[i].exp_ovf));
            takeResult();
            checkOutput($sformatf("vec%0d_sum_held", i), 32'(sum), 32'(vecs[i].exp_sum));
        end

        // Backpressure: result must sit still while a new request waits.
        applyStimulus(16'h1234, 16'h4321, 1'b0, 1'b0);
        in_valid = 1'b1;
        a        = 16'hFFFF;
        b        = 16'hFFFF;
        cin      = 1'b1;
        op_sub   = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            checkOutput("bp_out_valid", 32'(out_valid), 32'd1);
            checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
            checkOutput("bp_sum", 32'(sum), 32'h5555);
            checkOutput("bp_cout", 32'(cout), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        checkOutput("bp_take_in_ready", 32'(in_ready), 32'd1);
        checkOutput("bp_take_out_valid", 32'(out_valid), 32'd0);
        checkOutput("bp_take_sum", 32'(sum), 32'h5555);

        // Abort in the second RUN cycle: no result may appear.
        waitReady();
        a        = 16'h1111;
        b        = 16'h2222;
        cin      = 1'b0;
        op_sub   = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("abort_in_ready", 32'(in_ready), 32'd1);
        checkOutput("abort_out_valid", 32'(out_valid), 32'd0);
        checkOutput("abort_sum", 32'(sum), 32'h0);
        checkOutput("abort_cout", 32'(cout), 32'd0);
        checkOutput("abort_overflow", 32'(overflow), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        begin
            int seen;
            seen = 0;
            for (int k = 0; k < 8; k++) begin
                @(posedge clk);
                #1;
                if (out_valid) seen++;
            end
            checkOutput("abort_no_out_valid", 32'(seen), 32'd0);
        end
        checkOutput("abort_in_ready_after", 32'(in_ready), 32'd1);

        applyStimulus(16'h0F0F, 16'h00F1, 1'b0, 1'b0);
        checkOutput("post_abort_sum", 32'(sum), 32'h1000);
        checkOutput("post_abort_cout", 32'(cout), 32'd0);
        checkOutput("post_abort_overflow", 32'(overflow), 32'd0);
        takeResult();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
